acq_controller: RTL and testbench

- Sequences one acquisition cycle (pre-trigger fill, trigger wait, post-trigger fill, stop) by driving the channel buffer write enable.
- Schedules readout of CH1, CH2 and a status word onto the single shared TX path.
- Consumes the single-cycle request pulses from the PC request register: start, stop, CH1, CH2, trigger-status, reset.
- Sits between the request decode, trigger logic, channel RAM buffers and TX mux.

---
 rtl/acq_controller.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_acq_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acq_controller.sv
// -----------------------------------------------------------------------------
// acq_controller
//
// Purpose:
//   Sequences one acquisition cycle (pre-trigger fill, trigger wait,
//   post-trigger fill, stop) by driving the channel buffer write enable.
//   It also schedules readout of CH1, CH2 and a status word onto the single
//   shared TX path. Request pulses from the PC request register are latched
//   into sticky pending flags and granted one at a time.
//
// Parameters:
//   ADDR_WIDTH  buffer address width; the pre/post sample counter is this wide
//   TX_TIMEOUT  TX_BUSY cycles to wait for tx_done_i before aborting
//               (only used when ACQ_CTRL_TX_TIMEOUT_EN is defined)
//
// Optional feature macro:
//   ACQ_CTRL_TX_TIMEOUT_EN  enables the TX watchdog and sticky error bit 5
//
// Ports:
//   clk                 fpga clock
//   rst                 asynchronous reset, active-low
//   start_i             start request pulse
//   stop_i              stop request pulse
//   rqst_ch1_i          CH1 data request pulse
//   rqst_ch2_i          CH2 data request pulse
//   rqst_trig_status_i  status request pulse
//   soft_rst_i          PC reset request pulse (synchronous full clear)
//   pretrig_i           samples to store before trigger arming
//   posttrig_i          samples to store after trigger
//   sample_rdy_i        ADC sample strobe
//   trigger_i           trigger event pulse
//   write_en_o          buffer write enable (level)
//   tx_sel_o            TX source: 0 none, 1 CH1, 2 CH2, 3 status
//   tx_start_o          one-cycle pulse launching the selected transfer
//   tx_done_i           selected source finished transfer
//   status_o            [2:0] acq state, [3] triggered, [4] write_en,
//                       [5] tx error, [7:6] zero
// -----------------------------------------------------------------------------
module acq_controller #(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned TX_TIMEOUT = 65535
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  rqst_ch1_i,
  input  logic                  rqst_ch2_i,
  input  logic                  rqst_trig_status_i,
  input  logic                  soft_rst_i,
  input  logic [ADDR_WIDTH-1:0] pretrig_i,
  input  logic [ADDR_WIDTH-1:0] posttrig_i,
  input  logic                  sample_rdy_i,
  input  logic                  trigger_i,
  output logic                  write_en_o,
  output logic [1:0]            tx_sel_o,
  output logic                  tx_start_o,
  input  logic                  tx_done_i,
  output logic [7:0]            status_o
);

  typedef enum logic [2:0] {
    ACQ_IDLE      = 3'd0,
    ACQ_PRE_FILL  = 3'd1,
    ACQ_WAIT_TRIG = 3'd2,
    ACQ_POST_FILL = 3'd3,
    ACQ_STOPPED   = 3'd4
  } acq_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_BUSY  = 2'd2
  } tx_state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_CH1  = 2'd1;
  localparam logic [1:0] SEL_CH2  = 2'd2;
  localparam logic [1:0] SEL_STAT = 2'd3;

  // Pending flag indices
  localparam int P_CH1  = 0;
  localparam int P_CH2  = 1;
  localparam int P_STAT = 2;

  acq_state_t            acq_state_reg;
  tx_state_t             tx_state_reg;
  logic [ADDR_WIDTH-1:0] counter_reg;
  logic                  triggered_reg;
  logic [7:0]            status_snap_reg;
  logic [2:0]            pend_reg;
  logic [2:0]            rqst_vec;
  logic [2:0]            pend_clr;
  logic [7:0]            status_live;
  logic                  acq_quiet;
  logic                  ch_block;
  logic                  tx_finish;
  logic                  timeout_hit;
  logic                  tx_err;

  // Channel readout is only allowed while nothing is being written.
  assign acq_quiet = (acq_state_reg == ACQ_IDLE) || (acq_state_reg == ACQ_STOPPED);

  // A start that would overwrite a buffer under (or about to be under)
  // readout is dropped.
  assign ch_block = pend_reg[P_CH1] | pend_reg[P_CH2] | rqst_ch1_i | rqst_ch2_i;

  assign tx_finish = (tx_state_reg == TX_BUSY) && (tx_done_i || timeout_hit);

  // ---------------------------------------------------------------------------
  // Acquisition FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acq_state_reg <= ACQ_IDLE;
      counter_reg   <= '0;
      triggered_reg <= 1'b0;
      write_en_o    <= 1'b0;
    end else if (soft_rst_i) begin
      acq_state_reg <= ACQ_IDLE;
      counter_reg   <= '0;
      triggered_reg <= 1'b0;
      write_en_o    <= 1'b0;
    end else begin
      case (acq_state_reg)
        ACQ_IDLE, ACQ_STOPPED: begin
          // stop_i has no effect here, but still suppresses a coincident start
          if (start_i && !stop_i && !ch_block) begin
            acq_state_reg <= ACQ_PRE_FILL;
            counter_reg   <= '0;
            triggered_reg <= 1'b0;
            write_en_o    <= 1'b1;
          end
        end
        ACQ_PRE_FILL: begin
          // Trigger is deliberately not looked at until the pre-fill is done
          if (stop_i) begin
            acq_state_reg <= ACQ_STOPPED;
            write_en_o    <= 1'b0;
          end else if (counter_reg == pretrig_i) begin
            acq_state_reg <= ACQ_WAIT_TRIG;
          end else if (sample_rdy_i) begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        ACQ_WAIT_TRIG: begin
          if (stop_i) begin
            acq_state_reg <= ACQ_STOPPED;
            write_en_o    <= 1'b0;
          end else if (trigger_i) begin
            acq_state_reg <= ACQ_POST_FILL;
            triggered_reg <= 1'b1;
            counter_reg   <= '0;
          end
        end
        ACQ_POST_FILL: begin
          if (stop_i || (counter_reg == posttrig_i)) begin
            acq_state_reg <= ACQ_STOPPED;
            write_en_o    <= 1'b0;
          end else if (sample_rdy_i) begin
            counter_reg <= counter_reg + 1'b1;
          end
        end
        default: begin
          acq_state_reg <= ACQ_IDLE;
          write_en_o    <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky request flags: set by a pulse, cleared when the matching transfer
  // completes or aborts. A pulse coinciding with the clear is merged into the
  // transfer that is just finishing.
  // ---------------------------------------------------------------------------
  assign rqst_vec = {rqst_trig_status_i, rqst_ch2_i, rqst_ch1_i};

  always_comb begin
    pend_clr = '0;
    if (tx_finish) begin
      case (tx_sel_o)
        SEL_CH1:  pend_clr[P_CH1]  = 1'b1;
        SEL_CH2:  pend_clr[P_CH2]  = 1'b1;
        SEL_STAT: pend_clr[P_STAT] = 1'b1;
        default:  pend_clr         = '0;
      endcase
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_pend
    logic flag_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        flag_reg <= 1'b0;
      end else if (soft_rst_i) begin
        flag_reg <= 1'b0;
      end else begin
        flag_reg <= (flag_reg | rqst_vec[gi]) & ~pend_clr[gi];
      end
    end
    assign pend_reg[gi] = flag_reg;
  end

  // ---------------------------------------------------------------------------
  // TX scheduler FSM. Grants look only at registered pending flags, so a
  // stop arriving with a channel request has already moved the acq FSM to
  // STOPPED by the time the grant is evaluated.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_reg    <= TX_IDLE;
      tx_sel_o        <= SEL_NONE;
      tx_start_o      <= 1'b0;
      status_snap_reg <= '0;
    end else if (soft_rst_i) begin
      tx_state_reg    <= TX_IDLE;
      tx_sel_o        <= SEL_NONE;
      tx_start_o      <= 1'b0;
      status_snap_reg <= '0;
    end else begin
      case (tx_state_reg)
        TX_IDLE: begin
          tx_start_o <= 1'b0;
          if (pend_reg[P_STAT]) begin
            tx_state_reg    <= TX_START;
            tx_sel_o        <= SEL_STAT;
            tx_start_o      <= 1'b1;
            status_snap_reg <= status_live;
          end else if (acq_quiet && pend_reg[P_CH1]) begin
            tx_state_reg <= TX_START;
            tx_sel_o     <= SEL_CH1;
            tx_start_o   <= 1'b1;
          end else if (acq_quiet && pend_reg[P_CH2]) begin
            tx_state_reg <= TX_START;
            tx_sel_o     <= SEL_CH2;
            tx_start_o   <= 1'b1;
          end
        end
        TX_START: begin
          tx_start_o   <= 1'b0;
          tx_state_reg <= TX_BUSY;
        end
        TX_BUSY: begin
          if (tx_finish) begin
            tx_state_reg <= TX_IDLE;
            tx_sel_o     <= SEL_NONE;
          end
        end
        default: begin
          tx_state_reg <= TX_IDLE;
          tx_sel_o     <= SEL_NONE;
          tx_start_o   <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional TX watchdog
  // ---------------------------------------------------------------------------
`ifdef ACQ_CTRL_TX_TIMEOUT_EN
  localparam int TO_W = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;

  logic [TO_W-1:0] to_cnt_reg;
  logic            tx_err_reg;

  // The counter holds the number of completed busy cycles; the abort lands
  // on the edge ending busy cycle number TX_TIMEOUT.
  assign timeout_hit = (tx_state_reg == TX_BUSY) && !tx_done_i &&
                       (to_cnt_reg == TO_W'(TX_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt_reg <= '0;
      tx_err_reg <= 1'b0;
    end else if (soft_rst_i) begin
      to_cnt_reg <= '0;
      tx_err_reg <= 1'b0;
    end else begin
      if (tx_state_reg != TX_BUSY) begin
        to_cnt_reg <= '0;
      end else begin
        to_cnt_reg <= to_cnt_reg + 1'b1;
      end
      if (timeout_hit) begin
        tx_err_reg <= 1'b1;
      end else if (start_i) begin
        tx_err_reg <= 1'b0;
      end
    end
  end

  assign tx_err = tx_err_reg;
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign tx_err         = 1'b0;
  assign unused_timeout = ^TX_TIMEOUT;
`endif

  // ---------------------------------------------------------------------------
  // Status word: live unless a status transfer is selected, in which case the
  // value captured at grant time is held until that transfer ends.
  // ---------------------------------------------------------------------------
  assign status_live = {2'b00, tx_err, write_en_o, triggered_reg, acq_state_reg};
  assign status_o    = (tx_sel_o == SEL_STAT) ? status_snap_reg : status_live;

endmodule

// File: tb/tb_acq_controller.sv
// -----------------------------------------------------------------------------
// tb_acq_controller
//
// Directed bench for acq_controller. Expected TX grants are pushed to a queue
// when requests are driven; a monitor pops and compares on every tx_start_o.
// Status, write enable and select are compared against bench constants.
// -----------------------------------------------------------------------------
module tb_acq_controller;

`ifdef ACQ_CTRL_TX_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 16;
`else
  localparam int unsigned TB_TIMEOUT = 65535;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i, stop_i, rqst_ch1_i, rqst_ch2_i, rqst_trig_status_i;
  logic       soft_rst_i, sample_rdy_i, trigger_i, tx_done_i;
  logic [7:0] pretrig_i, posttrig_i;
  logic       write_en_o, tx_start_o;
  logic [1:0] tx_sel_o;
  logic [7:0] status_o;

  acq_controller #(
    .ADDR_WIDTH(8),
    .TX_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start_i           (start_i),
    .stop_i            (stop_i),
    .rqst_ch1_i        (rqst_ch1_i),
    .rqst_ch2_i        (rqst_ch2_i),
    .rqst_trig_status_i(rqst_trig_status_i),
    .soft_rst_i        (soft_rst_i),
    .pretrig_i         (pretrig_i),
    .posttrig_i        (posttrig_i),
    .sample_rdy_i      (sample_rdy_i),
    .trigger_i         (trigger_i),
    .write_en_o        (write_en_o),
    .tx_sel_o          (tx_sel_o),
    .tx_start_o        (tx_start_o),
    .tx_done_i         (tx_done_i),
    .status_o          (status_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         grant_cnt = 0;
  logic       prev_start = 1'b0;
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every launched transfer must match the next expected source
  always @(negedge clk) begin
    if (rst && tx_start_o) begin
      grant_cnt <= grant_cnt + 1;
      check("tx_start_pulse", {31'd0, prev_start}, 32'd0);
      if (exp_q.size() == 0) begin
        check("tx_unexpected_sel", {30'd0, tx_sel_o}, 32'd0);
      end else begin
        check("tx_sel", {30'd0, tx_sel_o}, {30'd0, exp_q.pop_front()});
      end
      $display("grant sel=%0d status=0x%02h t=%0t", tx_sel_o, status_o, $time);
    end
    prev_start <= tx_start_o;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe every 2nd cycle; the fill should leave on the cycle after the last strobe
  task automatic prefill(input int n);
    for (int k = 0; k < n; k++) begin
      sample_rdy_i = 1'b1;
      tick();
      check("pre_hold", {29'd0, status_o[2:0]}, 32'd1);
      sample_rdy_i = 1'b0;
      tick();
      check("pre_exit", {29'd0, status_o[2:0]}, (k == n - 1) ? 32'd2 : 32'd1);
    end
  endtask

  task automatic postfill(input int n);
    for (int k = 0; k < n; k++) begin
      sample_rdy_i = 1'b1;
      tick();
      check("post_we_hold", {31'd0, write_en_o}, 32'd1);
      sample_rdy_i = 1'b0;
      tick();
      check("post_we_exit", {31'd0, write_en_o}, (k == n - 1) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!tx_start_o && n < 40) begin
      tick();
      n++;
    end
    if (!tx_start_o) check(tag, 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    rst = 1'b0;
    {start_i, stop_i, rqst_ch1_i, rqst_ch2_i, rqst_trig_status_i} = '0;
    {soft_rst_i, sample_rdy_i, trigger_i, tx_done_i} = '0;
    pretrig_i  = 8'd4;
    posttrig_i = 8'd6;
    repeat (3) tick();
    check("rst_status", {24'd0, status_o}, 32'h00);
    check("rst_sel", {30'd0, tx_sel_o}, 32'd0);
    check("rst_we", {31'd0, write_en_o}, 32'd0);
    check("rst_start", {31'd0, tx_start_o}, 32'd0);
    rst = 1'b1;
    tick();
    check("idle_status", {24'd0, status_o}, 32'h00);

    // Full acquisition cycle
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("t1_we_rise", {31'd0, write_en_o}, 32'd1);
    check("t1_status_pre", {24'd0, status_o}, 32'h11);
    prefill(4);
    repeat (10) begin sample_rdy_i = ~sample_rdy_i; tick(); end
    sample_rdy_i = 1'b0;
    check("t1_wait", {24'd0, status_o}, 32'h12);
    trigger_i = 1'b1; tick(); trigger_i = 1'b0;
    check("t1_post", {24'd0, status_o}, 32'h1B);
    postfill(6);
    check("t1_stopped", {24'd0, status_o}, 32'h0C);

    // Trigger ignored in pre-fill, then manual stop
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("t2_restart", {24'd0, status_o}, 32'h11);
    trigger_i = 1'b1; tick(); trigger_i = 1'b0;
    check("t2_trig_ignored", {24'd0, status_o}, 32'h11);
    prefill(4);
    check("t2_wait", {24'd0, status_o}, 32'h12);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    check("t2_stopped", {24'd0, status_o}, 32'h04);
    check("t2_we_fall", {31'd0, write_en_o}, 32'd0);

    // Boundaries: start+stop together, zero-length fills
    pretrig_i = 8'd0; posttrig_i = 8'd0;
    start_i = 1'b1; stop_i = 1'b1; tick(); start_i = 1'b0; stop_i = 1'b0;
    check("b_stop_wins", {24'd0, status_o}, 32'h04);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("b_pre0_enter", {24'd0, status_o}, 32'h11);
    tick();
    check("b_pre0_exit", {24'd0, status_o}, 32'h12);
    trigger_i = 1'b1; tick(); trigger_i = 1'b0;
    check("b_post0_enter", {24'd0, status_o}, 32'h1B);
    tick();
    check("b_post0_exit", {24'd0, status_o}, 32'h0C);
    pretrig_i = 8'd4; posttrig_i = 8'd6;

    // CH1 + stop + CH2 in WAIT_TRIG, start dropped during readout
    start_i = 1'b1; tick(); start_i = 1'b0;
    prefill(4);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    rqst_ch1_i = 1'b1; stop_i = 1'b1; rqst_ch2_i = 1'b1; tick();
    rqst_ch1_i = 1'b0; stop_i = 1'b0; rqst_ch2_i = 1'b0;
    check("t3_stopped", {24'd0, status_o}, 32'h04);
    check("t3_no_early_grant", {31'd0, tx_start_o}, 32'd0);
    tick();
    check("t3_ch1_grant_time", {31'd0, tx_start_o}, 32'd1);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("t3_start_dropped", {24'd0, status_o}, 32'h04);
    check("t3_ch1_held", {30'd0, tx_sel_o}, 32'd1);
    tick();
    tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
    check("t3_ch1_release", {30'd0, tx_sel_o}, 32'd0);
    wait_grant("t3_ch2_timeout");
    check("t3_ch2_sel", {30'd0, tx_sel_o}, 32'd2);
    repeat (2) tick();
    tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
    check("t3_ch2_release", {30'd0, tx_sel_o}, 32'd0);
    tick();
    check("t3_sb_drained", exp_q.size(), 32'd0);
    check("t3_still_stopped", {24'd0, status_o}, 32'h04);

    // Status snapshot during POST_FILL
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("t4_start", {24'd0, status_o}, 32'h11);
    prefill(4);
    trigger_i = 1'b1; tick(); trigger_i = 1'b0;
    exp_q.push_back(2'd3);
    rqst_trig_status_i = 1'b1; tick(); rqst_trig_status_i = 1'b0;
    check("t4_no_early_grant", {31'd0, tx_start_o}, 32'd0);
    tick();
    check("t4_stat_grant", {31'd0, tx_start_o}, 32'd1);
    check("t4_snapshot", {24'd0, status_o}, 32'h1B);
    postfill(6);
    check("t4_frozen", {24'd0, status_o}, 32'h1B);
    check("t4_sel_held", {30'd0, tx_sel_o}, 32'd3);
    tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
    check("t4_release", {30'd0, tx_sel_o}, 32'd0);
    check("t4_live", {24'd0, status_o}, 32'h0C);

    // Soft reset abandons a transfer and drops pending CH2
    exp_q.push_back(2'd1);
    rqst_ch1_i = 1'b1; rqst_ch2_i = 1'b1; tick();
    rqst_ch1_i = 1'b0; rqst_ch2_i = 1'b0;
    wait_grant("t5_grant_timeout");
    tick();
    soft_rst_i = 1'b1; tick(); soft_rst_i = 1'b0;
    check("t5_sel_cleared", {30'd0, tx_sel_o}, 32'd0);
    check("t5_status_cleared", {24'd0, status_o}, 32'h00);
    g = grant_cnt;
    repeat (3) tick();
    tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
    repeat (5) tick();
    check("t5_no_grant", grant_cnt, g);
    check("t5_sel_idle", {30'd0, tx_sel_o}, 32'd0);
    check("t5_sb_drained", exp_q.size(), 32'd0);

`ifdef ACQ_CTRL_TX_TIMEOUT_EN
    // Watchdog abort after TB_TIMEOUT busy cycles
    exp_q.push_back(2'd3);
    rqst_trig_status_i = 1'b1; tick(); rqst_trig_status_i = 1'b0;
    tick();
    tick();
    repeat (TB_TIMEOUT - 1) tick();
    check("t6_still_busy", {30'd0, tx_sel_o}, 32'd3);
    tick();
    check("t6_aborted", {30'd0, tx_sel_o}, 32'd0);
    check("t6_err_set", {24'd0, status_o}, 32'h20);
    start_i = 1'b1; tick(); start_i = 1'b0;
    check("t6_err_cleared", {24'd0, status_o}, 32'h11);
    stop_i = 1'b1; tick(); stop_i = 1'b0;
    check("t6_sb_drained", exp_q.size(), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
